// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline sequencing controller for the 8-bit five-stage core.
//
// Drives advance enables and bubble-flushes for the PC and the IF/ID, ID/EX,
// EX/MEM and MEM/WB registers. It resolves three hazards:
//   - load-use: one-cycle bubble into ID/EX, PC and IF/ID hold
//   - taken branch in EX: two flushed fetch slots (sync instruction memory)
//   - multi-cycle data memory: full freeze, forced release after MEM_TIMEOUT
//
// Outputs are Mealy: combinational from state, cnt, flush_pend and the inputs.
//
// Ports
//   clock, reset                    clock; asynchronous active-high reset
//   id_src_a/b, id_src_a/b_used     ID-stage source registers and their use
//   ex_dst, ex_wen, ex_is_load      EX-stage destination / write enables / load
//   ex_branch_taken                 EX-stage branch resolved taken
//   mem_req, mem_ready              MEM-stage access request / completion
//   *_en, *_flush                   register advance enables / bubble loads
//   state                           RUN=0, MEM_WAIT=1, FLUSH=2
//   mem_timeout                     sticky: some access was force-released
//   stall_cnt_clr, stall_cycles     frozen-PC cycle counter (PIPE_CTRL_STALL_CNT_EN)
//
// Optional feature macro: PIPE_CTRL_STALL_CNT_EN adds the stall cycle counter.

module pipe_ctrl #(
  parameter int REG_ADDR_W  = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_src_a,
  input  logic [REG_ADDR_W-1:0] id_src_b,
  input  logic                  id_src_a_used,
  input  logic                  id_src_b_used,
  input  logic [REG_ADDR_W-1:0] ex_dst,
  input  logic [1:0]            ex_wen,
  input  logic                  ex_is_load,
  input  logic                  ex_branch_taken,
  input  logic                  mem_req,
  input  logic                  mem_ready,
  output logic                  pc_en,
  output logic                  if_id_en,
  output logic                  id_ex_en,
  output logic                  ex_mem_en,
  output logic                  mem_wb_en,
  output logic                  if_id_flush,
  output logic                  id_ex_flush,
  output logic                  ex_mem_flush,
  output logic                  mem_wb_flush,
  output logic [1:0]            state,
`ifdef PIPE_CTRL_STALL_CNT_EN
  input  logic                  stall_cnt_clr,
  output logic [CNT_W-1:0]      stall_cycles,
`endif
  output logic                  mem_timeout
);

  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO = CW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t        st;
  logic [CW-1:0] cnt;
  logic          flush_pend;

  logic memstall, loaduse, rel, forced, freeze, eval, br, lu;

  assign state = st;

  always_comb begin
    memstall = mem_req & ~mem_ready;
    loaduse  = ex_is_load & (ex_wen != 2'b00) &
               ((id_src_a_used & (id_src_a == ex_dst)) |
                (id_src_b_used & (id_src_b == ex_dst)));
    // Release cycle: data arrived, or the wait hit its cap and is forced out.
    rel      = (st == MEM_WAIT) & (mem_ready | (cnt == TO));
    forced   = rel & ~mem_ready;
    freeze   = ((st == RUN || st == FLUSH) & memstall) |
               ((st == MEM_WAIT) & ~rel);
    // Branch / load-use are only looked at in RUN and on a release cycle;
    // in FLUSH ID/EX holds a bubble so neither can be real.
    eval     = ~freeze & ((st == RUN) | rel);
    br       = eval & ex_branch_taken;
    lu       = eval & ~ex_branch_taken & loaduse;

    pc_en        = ~freeze & ~lu;
    if_id_en     = ~freeze & ~lu;
    id_ex_en     = ~freeze;
    ex_mem_en    = ~freeze;
    mem_wb_en    = ~freeze;
    // A branch interrupted by a memory stall in FLUSH still owes one IF/ID
    // flush; it is paid on the release cycle.
    if_id_flush  = br | ((st == FLUSH) & ~freeze) | (rel & flush_pend);
    id_ex_flush  = br | lu;
    ex_mem_flush = 1'b0;
    // The stalled MEM instruction must not be retired repeatedly, and a
    // forced release retires nothing valid.
    mem_wb_flush = freeze | forced;

    if (reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st          <= RUN;
      cnt         <= '0;
      flush_pend  <= 1'b0;
      mem_timeout <= 1'b0;
    end else if (freeze) begin
      if (st == MEM_WAIT) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= CW'(1);
        st  <= MEM_WAIT;
        if (st == FLUSH) flush_pend <= 1'b1;
      end
    end else if (rel) begin
      cnt        <= '0;
      flush_pend <= 1'b0;
      st         <= (ex_branch_taken | flush_pend) ? FLUSH : RUN;
      if (forced) mem_timeout <= 1'b1;
    end else if (st == RUN) begin
      st <= br ? FLUSH : RUN;
    end else begin
      st <= RUN;
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      stall_cycles <= '0;
    else if (stall_cnt_clr)
      stall_cycles <= '0;
    else if (!pc_en && stall_cycles != '1)
      stall_cycles <= stall_cycles + CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl. Inputs change on the falling edge; outputs
// are checked 1 ns later, well before the next rising edge.
module tb_pipe_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [4:0] id_src_a, id_src_b, ex_dst;
  logic       id_src_a_used, id_src_b_used;
  logic [1:0] ex_wen;
  logic       ex_is_load, ex_branch_taken, mem_req, mem_ready;
  logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic [1:0] state;
  logic       mem_timeout;
`ifdef PIPE_CTRL_STALL_CNT_EN
  logic        stall_cnt_clr;
  logic [15:0] stall_cycles;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pipe_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(15), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .id_src_a(id_src_a), .id_src_b(id_src_b),
    .id_src_a_used(id_src_a_used), .id_src_b_used(id_src_b_used),
    .ex_dst(ex_dst), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
    .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
    .state(state),
`ifdef PIPE_CTRL_STALL_CNT_EN
    .stall_cnt_clr(stall_cnt_clr), .stall_cycles(stall_cycles),
`endif
    .mem_timeout(mem_timeout)
  );

  wire [4:0] en = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en};
  wire [3:0] fl = {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check enables, flushes and state in the current cycle.
  task automatic cyc(input string tag, input logic [4:0] e, input logic [3:0] f,
                     input logic [1:0] s);
    #1;
    chk({tag, ".en"}, 32'(en), 32'(e));
    chk({tag, ".fl"}, 32'(fl), 32'(f));
    chk({tag, ".st"}, 32'(state), 32'(s));
  endtask

  task automatic idle();
    id_src_a = 5'd0; id_src_b = 5'd0; ex_dst = 5'd0;
    id_src_a_used = 1'b0; id_src_b_used = 1'b0;
    ex_wen = 2'b00; ex_is_load = 1'b0; ex_branch_taken = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
`ifdef PIPE_CTRL_STALL_CNT_EN
    stall_cnt_clr = 1'b0;
`endif
  endtask

  task automatic set_lu();
    ex_is_load = 1'b1; ex_wen = 2'b01; ex_dst = 5'd3;
    id_src_a = 5'd3; id_src_a_used = 1'b1;
  endtask

  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] LUE = 5'b00111;

  initial begin
    idle();
    reset = 1'b1;
    #2;
    cyc("rst", NONE, 4'b1111, 2'd0);
    chk("rst.to", 32'(mem_timeout), 32'd0);
    @(negedge clock); @(negedge clock);
    reset = 1'b0;
    cyc("run_idle", ALL, 4'b0000, 2'd0);

    // load-use hit, then no hazard
    @(negedge clock); set_lu();
    cyc("lu", LUE, 4'b0100, 2'd0);
    @(negedge clock); idle();
    cyc("lu_after", ALL, 4'b0000, 2'd0);
    @(negedge clock); set_lu(); id_src_a_used = 1'b0;
    cyc("lu_unused", ALL, 4'b0000, 2'd0);
    @(negedge clock); set_lu(); ex_wen = 2'b00;
    cyc("lu_nowen", ALL, 4'b0000, 2'd0);
    @(negedge clock); idle(); ex_is_load = 1'b1; ex_wen = 2'b10; ex_dst = 5'd9;
    id_src_b = 5'd9; id_src_b_used = 1'b1;
    cyc("lu_srcb", LUE, 4'b0100, 2'd0);

    // taken branch together with load-use: branch wins
    @(negedge clock); idle(); set_lu(); ex_branch_taken = 1'b1;
    cyc("br", ALL, 4'b1100, 2'd0);
    @(negedge clock); idle();
    cyc("br_flush", ALL, 4'b1000, 2'd2);
    @(negedge clock);
    cyc("br_done", ALL, 4'b0000, 2'd0);

    // memory wait: 4 low cycles then ready
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); mem_req = 1'b1; mem_ready = 1'b0;
      cyc($sformatf("mw%0d", i), NONE, 4'b0001, (i == 0) ? 2'd0 : 2'd1);
    end
    @(negedge clock); mem_ready = 1'b1;
    cyc("mw_rel", ALL, 4'b0000, 2'd1);
    @(negedge clock); idle();
    cyc("mw_after", ALL, 4'b0000, 2'd0);
    chk("mw_to", 32'(mem_timeout), 32'd0);

    // timeout: 15 frozen, forced release on the 16th
    for (int i = 0; i < 15; i++) begin
      @(negedge clock); mem_req = 1'b1; mem_ready = 1'b0;
      cyc($sformatf("to%0d", i), NONE, 4'b0001, (i == 0) ? 2'd0 : 2'd1);
    end
    @(negedge clock);
    cyc("to_rel", ALL, 4'b0001, 2'd1);
    chk("to_rel_flag", 32'(mem_timeout), 32'd0);
    @(negedge clock); idle();
    cyc("to_after", ALL, 4'b0000, 2'd0);
    chk("to_flag", 32'(mem_timeout), 32'd1);
    @(negedge clock); @(negedge clock);
    chk("to_sticky", 32'(mem_timeout), 32'd1);

    // memory stall in FLUSH: deferred IF/ID flush on release
    @(negedge clock); ex_branch_taken = 1'b1;
    cyc("fm_br", ALL, 4'b1100, 2'd0);
    @(negedge clock); idle(); mem_req = 1'b1;
    cyc("fm_frz", NONE, 4'b0001, 2'd2);
    @(negedge clock); mem_ready = 1'b1;
    cyc("fm_rel", ALL, 4'b1000, 2'd1);
    @(negedge clock); idle();
    cyc("fm_flush", ALL, 4'b1000, 2'd2);
    @(negedge clock);
    cyc("fm_done", ALL, 4'b0000, 2'd0);

`ifdef PIPE_CTRL_STALL_CNT_EN
    @(negedge clock); stall_cnt_clr = 1'b1;
    @(negedge clock); stall_cnt_clr = 1'b0; set_lu();
    @(negedge clock);
    @(negedge clock);
    @(negedge clock); idle();
    #1 chk("sc3", 32'(stall_cycles), 32'd3);
    @(negedge clock); stall_cnt_clr = 1'b1; set_lu();
    @(negedge clock); stall_cnt_clr = 1'b0; idle();
    #1 chk("sc_clr", 32'(stall_cycles), 32'd0);
    @(negedge clock); set_lu();
    repeat (65540) @(negedge clock);
    idle();
    #1 chk("sc_sat", 32'(stall_cycles), 32'hFFFF);
`endif

    // reset asynchronously in the middle of a memory wait
    @(negedge clock); idle(); mem_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1 chk("rm_st", 32'(state), 32'd1);
    #2 reset = 1'b1;
    cyc("rm", NONE, 4'b1111, 2'd0);
    chk("rm_to", 32'(mem_timeout), 32'd0);
`ifdef PIPE_CTRL_STALL_CNT_EN
    chk("rm_sc", 32'(stall_cycles), 32'd0);
`endif
    @(negedge clock); reset = 1'b0; idle();
    cyc("rm_run", ALL, 4'b0000, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 8-bit core's five-stage datapath. It drives the enable and flush inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and resolves three hazards:

- load-use data hazards (one-cycle bubble)
- taken branches resolved in EX (two-cycle flush, because instruction memory is synchronous)
- multi-cycle data-memory accesses (full freeze, with a timeout)

## Interface
- REG_ADDR_W, 5: register-file address width
- MEM_TIMEOUT, 15: maximum frozen cycles per memory access (≥2)
- CNT_W, 16: stall counter width
- clock  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- id_src_a / id_src_b  in  REG_ADDR_W  ID-stage source register addresses
- id_src_a_used / id_src_b_used  in  1  source operand actually read
- ex_dst  in  REG_ADDR_W  EX-stage destination register
- ex_wen  in  2  EX-stage register-file write enables (top/bot)
- ex_is_load  in  1  EX-stage instruction is a memory load
- ex_branch_taken  in  1  EX-stage branch resolved taken
- mem_req  in  1  MEM-stage instruction accesses data memory
- mem_ready  in  1  data memory completes access this cycle
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1  register advance enables
- if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush  out  1  load bubble (all-zero instruction, wen=0)
- state  out  2  RUN=0, MEM_WAIT=1, FLUSH=2
- mem_timeout  out  1  sticky: a memory access timed out
- stall_cnt_clr  in  1  synchronous clear of stall_cycles (macro only)
- stall_cycles  out  CNT_W  frozen-PC cycle count (macro only)

## Operation
- Outputs are combinational from the registered state, `cnt`, `flush_pend` and the current inputs (Mealy).
- Default in RUN with no hazard: all enables 1, all flushes 0.
- Flush has priority over enable at the target register.

Conditions:
- memstall = mem_req & ~mem_ready
- loaduse = ex_is_load & (ex_wen≠0) & ((id_src_a_used & id_src_a==ex_dst) | (id_src_b_used & id_src_b==ex_dst))

Priority each cycle: memstall > branch > load-use.

RUN:
- memstall: all enables 0, mem_wb_flush=1, cnt←1, go MEM_WAIT.
- else ex_branch_taken: if_id_flush=1, id_ex_flush=1, pc_en=1; go FLUSH.
- else loaduse: pc_en=0, if_id_en=0, id_ex_flush=1, EX/MEM and MEM/WB advance; stay in RUN.

MEM_WAIT:
- ~mem_ready and cnt<MEM_TIMEOUT: freeze as above, cnt←cnt+1.
- mem_ready, or cnt==MEM_TIMEOUT (forced release): this is the release cycle.
  - Forced release only: mem_wb_flush=1, mem_timeout←1.
  - Enables are 1 and branch/load-use are evaluated exactly as in RUN; a flush or bubble applies in this cycle.
  - Next state: FLUSH if ex_branch_taken or flush_pend, else RUN. cnt←0.

FLUSH (the wrong-path fetch is arriving):
- if_id_flush=1; other stages advance normally; load-use is not evaluated; go RUN.
- memstall in FLUSH: freeze, flush_pend←1, cnt←1, go MEM_WAIT. flush_pend is cleared on release and that release cycle asserts if_id_flush.
- ex_branch_taken in FLUSH cannot occur, because ID/EX holds a bubble.

Reset (asynchronous):
- state=RUN, cnt=0, flush_pend=0, mem_timeout=0, stall_cycles=0.
- While reset is high, all enables are 0 and all flushes are 1.

## Timing
- Hazard response is zero-latency: enables and flushes change in the same cycle as the inputs.
- A load-use stall is exactly 1 cycle.
- A taken branch costs exactly 2 flushed fetch slots.
- A memory stall freezes for N cycles, where N is the number of cycles mem_ready stays low, capped at MEM_TIMEOUT. Release is the following cycle.
- mem_timeout rises on the clock edge that ends the forced-release cycle.
- mem_ready high in the same cycle as mem_req: no stall.

## Configuration
- PIPE_CTRL_STALL_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_en=0 and reset low, saturating at all-ones.
  - stall_cnt_clr has priority and clears it to 0.
- Undefined: stall_cnt_clr and stall_cycles ports and their logic are absent. Everything else is identical.

## Test plan
- Load-use: ex_is_load=1, ex_wen=01, ex_dst=3, id_src_a=3 used → one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; the next cycle has all enables 1. Repeat with id_src_a_used=0 → no stall.
- Branch: ex_branch_taken=1 in RUN → if_id_flush and id_ex_flush that cycle; FLUSH with if_id_flush next cycle; state returns to 0.
- Memory wait: mem_req=1, mem_ready low for 4 cycles then high → 4 frozen cycles with mem_wb_flush=1, release on cycle 5, mem_timeout stays 0.
- Timeout: MEM_TIMEOUT=15, mem_ready never asserted → 15 frozen cycles, forced release on the 16th, mem_timeout=1 until reset.
- Simultaneous events: branch plus load-use in RUN → branch wins with no stall. Memory stall during FLUSH → after release, if_id_flush is asserted on the release cycle.
- Reset mid-MEM_WAIT: assert reset asynchronously → state=0, all flushes 1, stall_cycles=0 (macro build); stall_cycles saturates at 0xFFFF under a forced long stall with CNT_W=16.
